// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, debug and memory-side signals of the instruction-memory port arbiter
interface imem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
);
  logic                  f_req;
  logic [ADDR_WIDTH-3:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [INSN_WIDTH-1:0] f_rdata;
  logic                  flush;
  logic                  d_req;
  logic [ADDR_WIDTH-3:0] d_addr;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [INSN_WIDTH-1:0] d_rdata;
  logic                  mem_en;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [INSN_WIDTH-1:0] mem_rdata;
  modport slave (
    input  f_req, f_addr, flush, d_req, d_addr, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_addr
  );
  modport master (
    output f_req, f_addr, flush, d_req, d_addr, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_addr
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction-memory read port between fetch and a debug/loader requester
// Optional starvation guard for debug enabled by defining IMEM_ARB_STARVE_GUARD_EN.
module imem_port_arbiter
`ifdef IMEM_ARB_STARVE_GUARD_EN
  #(parameter int unsigned STARVE_LIMIT = 8)
`endif
(
  input logic clk,
  input logic rst,
  imem_port_arbiter_if.slave bus
);
  logic r_own_f;
  logic r_own_d;
  logic w_force_d;
  logic w_f_gnt;
  logic w_d_gnt;
`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic [7:0] r_starve_cnt;
  assign w_force_d = bus.d_req & (r_starve_cnt == 8'(STARVE_LIMIT));
  // Count cycles debug is blocked by fetch; any debug grant or idle debug clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_starve_cnt <= '0;
    else r_starve_cnt <= (w_d_gnt | ~bus.d_req) ? 8'd0 : bus.f_req ? r_starve_cnt + 8'd1 : r_starve_cnt;
  end
`else
  assign w_force_d = 1'b0;
`endif
  // Fetch has priority unless the starvation guard forces debug; nothing granted in reset
  always_comb begin
    w_f_gnt = rst & bus.f_req & ~w_force_d;
    w_d_gnt = rst & bus.d_req & (~bus.f_req | w_force_d);
  end
  assign bus.f_gnt    = w_f_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.mem_en   = w_f_gnt | w_d_gnt;
  assign bus.mem_addr = w_d_gnt ? bus.d_addr : bus.f_addr;
  // Remember which requester owns the response returning next cycle; a flush kills fetch ownership
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_own_f <= 1'b0;
      r_own_d <= 1'b0;
    end else begin
      r_own_f <= w_f_gnt & ~bus.flush;
      r_own_d <= w_d_gnt;
    end
  end
  assign bus.f_rvalid = r_own_f & ~bus.flush;
  assign bus.d_rvalid = r_own_d;
  assign bus.f_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;
endmodule
